// File: rtl/multiplicador_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multiplicador_pkg;

    localparam int WIDTH_DEF   = 16;   // operand width, product is twice this
    localparam int TIMEOUT_DEF = 64;   // WAIT cycles before the watchdog aborts

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: favours the requester that was not granted last.
// Latency: grant is combinational; pointer updates on the clock after i_upd.
// Backpressure: none; caller decides when a grant is consumed.
//
// Ports: i_clock/i_rst (async active-low), i_req[1:0] request vector,
//        i_upd pulse + i_owner to record the last served requester,
//        o_grant[1:0] one-hot grant (zero when nobody requests).
module rr_arbiter2 (
    input  logic       i_clock,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_owner,
    output logic [1:0] o_grant
);

    logic r_last;

    // Pointer resets to 1 so requester 0 wins the first contested grant.
    always_ff @(posedge i_clock or negedge i_rst) begin
        if (!i_rst) begin
            r_last <= 1'b1;
        end else if (i_upd) begin
            r_last <= i_owner;
        end
    end

    always_comb begin
        o_grant = 2'b00;
        if (i_req[0] && i_req[1]) begin
            o_grant = r_last ? 2'b01 : 2'b10;
        end else if (i_req[0]) begin
            o_grant = 2'b01;
        end else if (i_req[1]) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/multiplicador_arbitro.sv
// Shares one sequential multiplier between two requesters, round-robin, with a watchdog.
// Latency: ack same cycle as accept, mul_start +1, res_valid the cycle after mul_Done.
// Backpressure: result held in RESP until the owner's res_ready; new requests wait.
//
// Ports: i_clock, i_rst (async active-low);
//        per requester N: i_reqN, i_aN, i_bN, o_ackN, o_res_validN, i_res_readyN;
//        shared: o_res (product), o_err (watchdog abort), o_busy;
//        multiplier side: o_mul_start, o_mul_multiplicador2, o_mul_multiplicando,
//        i_mul_produto, i_mul_Idle, i_mul_Done.
module multiplicador_arbitro
    import multiplicador_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               i_clock,
    input  logic               i_rst,
    input  logic               i_req0,
    input  logic [WIDTH-1:0]   i_a0,
    input  logic [WIDTH-1:0]   i_b0,
    output logic               o_ack0,
    output logic               o_res_valid0,
    input  logic               i_res_ready0,
    input  logic               i_req1,
    input  logic [WIDTH-1:0]   i_a1,
    input  logic [WIDTH-1:0]   i_b1,
    output logic               o_ack1,
    output logic               o_res_valid1,
    input  logic               i_res_ready1,
    output logic [2*WIDTH-1:0] o_res,
    output logic               o_err,
    output logic               o_busy,
    output logic               o_mul_start,
    output logic [WIDTH-1:0]   o_mul_multiplicador2,
    output logic [WIDTH-1:0]   o_mul_multiplicando,
    input  logic [2*WIDTH-1:0] i_mul_produto,
    input  logic               i_mul_Idle,
    input  logic               i_mul_Done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             r_state, w_state_nxt;
    logic               r_owner;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [2*WIDTH-1:0] r_res;
    logic               r_err;
    logic [CW-1:0]      r_cnt;

    logic [1:0] w_grant;
    logic       w_win;
    logic       w_accept;
    logic       w_owner_rdy;
    logic       w_xfer;
    logic       w_timeout;

    rr_arbiter2 u_arb (
        .i_clock (i_clock),
        .i_rst   (i_rst),
        .i_req   ({i_req1, i_req0}),
        .i_upd   (w_xfer),
        .i_owner (r_owner),
        .o_grant (w_grant)
    );

    assign w_win       = w_grant[1];
    assign w_accept    = (r_state == ST_IDLE) && i_mul_Idle && (w_grant != 2'b00);
    assign w_owner_rdy = r_owner ? i_res_ready1 : i_res_ready0;
    assign w_xfer      = (r_state == ST_RESP) && w_owner_rdy;
    // Counter holds the number of WAIT cycles already spent; this is the last allowed one.
    assign w_timeout   = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clock or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs. The acks are combinational on the
    // request, so they are also gated by reset to stay low while it is asserted.
    always_comb begin
        w_state_nxt  = r_state;
        o_ack0       = 1'b0;
        o_ack1       = 1'b0;
        o_mul_start  = 1'b0;
        o_res_valid0 = 1'b0;
        o_res_valid1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                    o_ack0      = i_rst && !w_win;
                    o_ack1      = i_rst && w_win;
                end
            end
            ST_ISSUE: begin
                o_mul_start = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_mul_Done || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                o_res_valid0 = !r_owner;
                o_res_valid1 = r_owner;
                if (w_xfer) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_rst) begin
        if (!i_rst) begin
            r_owner <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_win;
                        r_a     <= w_win ? i_a1 : i_a0;
                        r_b     <= w_win ? i_b1 : i_b0;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    // A Done arriving on the timeout cycle still delivers the product.
                    if (i_mul_Done) begin
                        r_res <= i_mul_produto;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_res                = r_res;
    assign o_err                = r_err;
    assign o_busy               = (r_state != ST_IDLE);
    assign o_mul_multiplicador2 = r_a;
    assign o_mul_multiplicando  = r_b;

endmodule

// File: tb/tb_multiplicador_arbitro.sv
module tb_multiplicador_arbitro;

    localparam int W  = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic ack0, ack1, rv0, rv1, rr0, rr1;
    logic [2*W-1:0] res;
    logic err, busy, mul_start;
    logic [W-1:0] mop_a, mop_b;
    logic [2*W-1:0] mul_produto;
    logic mul_Idle, mul_Done;

    always #5 clk = ~clk;

    multiplicador_arbitro #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clock              (clk),
        .i_rst                (rst_n),
        .i_req0               (req0),
        .i_a0                 (a0),
        .i_b0                 (b0),
        .o_ack0               (ack0),
        .o_res_valid0         (rv0),
        .i_res_ready0         (rr0),
        .i_req1               (req1),
        .i_a1                 (a1),
        .i_b1                 (b1),
        .o_ack1               (ack1),
        .o_res_valid1         (rv1),
        .i_res_ready1         (rr1),
        .o_res                (res),
        .o_err                (err),
        .o_busy               (busy),
        .o_mul_start          (mul_start),
        .o_mul_multiplicador2 (mop_a),
        .o_mul_multiplicando  (mop_b),
        .i_mul_produto        (mul_produto),
        .i_mul_Idle           (mul_Idle),
        .i_mul_Done           (mul_Done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready lines: either manual or randomized per cycle.
    bit   rdy_rand = 0;
    logic man_rr0, man_rr1, rnd_rr0, rnd_rr1;
    assign rr0 = rdy_rand ? rnd_rr0 : man_rr0;
    assign rr1 = rdy_rand ? rnd_rr1 : man_rr1;
    initial begin
        rnd_rr0 = 1'b0;
        rnd_rr1 = 1'b0;
        forever begin
            @(posedge clk); #1;
            rnd_rr0 = 1'($urandom_range(0, 1));
            rnd_rr1 = 1'($urandom_range(0, 1));
        end
    end

    // Multiplier model: Done pulses mul_lat cycles after the start cycle.
    int   mul_lat  = 16;
    bit   mul_hang = 0;
    bit   idle_low = 0;
    bit   m_busy   = 0;
    int   m_cnt    = 0;
    bit   start_seen = 0;
    logic [W-1:0] m_a, m_b;
    initial begin
        mul_Done    = 1'b0;
        mul_produto = '0;
        mul_Idle    = 1'b1;
        forever begin
            @(posedge clk); #1;
            mul_Done    = 1'b0;
            mul_produto = $urandom;
            if (!rst_n) begin
                m_busy = 0;
            end else if (start_seen && !mul_hang) begin
                m_busy = 1;
                m_cnt  = mul_lat - 1;
                m_a    = mop_a;
                m_b    = mop_b;
            end else if (m_busy && m_cnt > 0) begin
                m_cnt--;
            end
            if (m_busy && m_cnt == 0) begin
                mul_Done    = 1'b1;
                mul_produto = 32'(m_a) * 32'(m_b);
                m_busy      = 0;
            end
            mul_Idle = !m_busy && !idle_low;
        end
    end

    // Scoreboard: expected {err, res} per requester, pushed at issue time.
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    bit   exp_err = 0;

    // Monitor with an abstract fairness model: contested grant goes to whoever was not served last.
    bit   ref_last = 1;
    logic [1:0]  want_g;
    logic [32:0] e_g;
    int   ack_cyc = -10, start_cyc = -10, done_cyc = -10;
    bit   prev_rv0 = 0, prev_rv1 = 0, prev_acc = 0, acc_g;
    logic [2*W-1:0] prev_res;
    logic prev_err;

    always @(negedge clk) begin
        start_seen = mul_start;
        if (!rst_n) begin
            ref_last = 1;
            prev_rv0 = 0;
            prev_rv1 = 0;
            prev_acc = 0;
        end else begin
            if (ack0 || ack1) begin
                if (req0 && req1) want_g = ref_last ? 2'b01 : 2'b10;
                else              want_g = {req1, req0};
                check("ack_winner", 64'({ack1, ack0}), 64'(want_g));
                check("ack_needs_idle", 64'(mul_Idle), 64'(1'b1));
                ack_cyc = cyc;
            end
            if (mul_start) begin
                check("start_after_ack", 64'(cyc - ack_cyc), 64'(1));
                start_cyc = cyc;
            end
            if (mul_Done) done_cyc = cyc;
            if ((rv0 && !prev_rv0) || (rv1 && !prev_rv1)) begin
                if (done_cyc > start_cyc) check("valid_after_done", 64'(cyc - done_cyc), 64'(1));
                else                      check("timeout_latency", 64'(cyc - start_cyc), 64'(TO + 1));
            end
            if ((prev_rv0 || prev_rv1) && !prev_acc) begin
                check("valid_held", 64'({rv1, rv0}), 64'({prev_rv1, prev_rv0}));
                check("res_held", 64'({err, res}), 64'({prev_err, prev_res}));
            end
            if (prev_acc) check("valid_drops", 64'({rv1, rv0}), 64'(0));
            if (rv0 || rv1) check("one_valid", 64'(rv0 & rv1), 64'(0));
            if (rv0 && rr0) begin
                if (exp_q0.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_res0: got 0x%0h, want no result", res);
                end else begin
                    e_g = exp_q0.pop_front();
                    check("res0", 64'({err, res}), 64'(e_g));
                end
                ref_last = 0;
            end
            if (rv1 && rr1) begin
                if (exp_q1.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_res1: got 0x%0h, want no result", res);
                end else begin
                    e_g = exp_q1.pop_front();
                    check("res1", 64'({err, res}), 64'(e_g));
                end
                ref_last = 1;
            end
            acc_g    = (rv0 && rr0) || (rv1 && rr1);
            prev_acc = acc_g;
            prev_rv0 = rv0;
            prev_rv1 = rv1;
            prev_res = res;
            prev_err = err;
        end
    end

    task automatic do_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
        int k = 0;
        logic [32:0] e;
        @(posedge clk); #1;
        e = {exp_err, exp_err ? 32'd0 : 32'(a) * 32'(b)};
        if (p == 0) begin req0 = 1; a0 = a; b0 = b; exp_q0.push_back(e); end
        else        begin req1 = 1; a1 = a; b1 = b; exp_q1.push_back(e); end
        forever begin
            @(negedge clk);
            if ((p == 0 && ack0) || (p == 1 && ack1)) break;
            k++;
            if (k > 500) begin
                n_tests++; n_fail++;
                $display("FAIL ack_timeout: port %0d got no ack, want ack within 500 cycles", p);
                break;
            end
        end
        @(posedge clk); #1;
        if (p == 0) begin req0 = 0; a0 = W'($urandom); b0 = W'($urandom); end
        else        begin req1 = 0; a1 = W'($urandom); b1 = W'($urandom); end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: pending %0d/%0d busy %0b, want empty", exp_q0.size(), exp_q1.size(), busy);
        end
    endtask

    initial begin
        logic [W-1:0] sa, sb;
        int k;
        rst_n = 0; req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        man_rr0 = 1; man_rr1 = 1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_ctrl", 64'({ack0, ack1, rv0, rv1, mul_start, err, busy}), 64'(0));
        check("reset_data", {mop_a, mop_b, res}, 64'(0));
        @(posedge clk); #2 rst_n = 1;

        // Single request, then a lone port-1 request.
        do_req(0, 16'd2001, 16'd4001);
        wait_drain();
        do_req(1, W'($urandom), W'($urandom));
        wait_drain();

        // Contested pairs: 0 first, then 1, alternating.
        for (int i = 0; i < 4; i++) begin
            if (i == 0) fork do_req(0, 16'd2001, 16'd4001); do_req(1, 16'd22, 16'd47); join
            else        fork do_req(0, W'($urandom), W'($urandom)); do_req(1, W'($urandom), W'($urandom)); join
        end
        wait_drain();

        // Owner stalls 10 cycles; non-owner ready and a pending request must not disturb RESP.
        sa = W'($urandom); sb = W'($urandom);
        man_rr0 = 0; man_rr1 = 1;
        fork
            do_req(0, sa, sb);
            begin
                repeat (20) @(posedge clk);
                do_req(1, W'($urandom), W'($urandom));
            end
            begin
                k = 0;
                while (!rv0 && k < 300) begin @(negedge clk); k++; end
                check("stall_seen", 64'(rv0), 64'(1));
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    check("stall_valid", 64'(rv0), 64'(1));
                    check("stall_res", 64'({err, res}), {31'd0, 1'b0, 32'(sa) * 32'(sb)});
                    check("stall_quiet", 64'({mul_start, ack0, ack1}), 64'(0));
                end
                @(posedge clk); #1 man_rr0 = 1;
                @(negedge clk); check("stall_accept", 64'(rv0), 64'(1));
                @(negedge clk); check("stall_done", 64'(rv0), 64'(0));
            end
        join
        wait_drain();

        // Watchdog abort, then a normal transaction.
        mul_hang = 1; exp_err = 1;
        do_req(0, W'($urandom), W'($urandom));
        wait_drain();
        mul_hang = 0; exp_err = 0;
        do_req(1, W'($urandom), W'($urandom));
        wait_drain();

        // Request dropped before ack, then ack exactly when the multiplier becomes idle.
        @(negedge clk); idle_low = 1;
        @(posedge clk); #1 req0 = 1;
        @(posedge clk); #1 req0 = 0;
        fork
            do_req(1, W'($urandom), W'($urandom));
            begin
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check("idle_low_quiet", 64'({ack0, ack1, mul_start, busy}), 64'(0));
                end
                idle_low = 0;
                @(negedge clk);
                check("ack_on_idle", 64'({mul_Idle, ack1}), 64'(2'b11));
            end
        join
        wait_drain();

        // Reset during WAIT after a port-0 completion.
        do_req(0, W'($urandom), W'($urandom));
        wait_drain();
        do_req(1, W'($urandom), W'($urandom));
        repeat (4) @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("midrst_ctrl", 64'({ack0, ack1, rv0, rv1, mul_start, err, busy}), 64'(0));
        check("midrst_data", {mop_a, mop_b, res}, 64'(0));
        exp_q0.delete(); exp_q1.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        fork do_req(0, W'($urandom), W'($urandom)); do_req(1, W'($urandom), W'($urandom)); join
        wait_drain();

        // Randomized traffic with random latency and backpressure.
        rdy_rand = 1;
        for (int it = 0; it < 24; it++) begin
            mul_lat = $urandom_range(1, 20);
            case ($urandom_range(0, 2))
                0:       do_req(0, W'($urandom), W'($urandom));
                1:       do_req(1, W'($urandom), W'($urandom));
                default: fork do_req(0, W'($urandom), W'($urandom)); do_req(1, W'($urandom), W'($urandom)); join
            endcase
            if ($urandom_range(0, 1) == 1) wait_drain();
        end
        wait_drain();
        rdy_rand = 0;

        check("queues_empty", 64'(exp_q0.size() + exp_q1.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplicador_arbitro.md
Name: multiplicador_arbitro

Overview:
- Shares one sequential 16x16 multiplier (multiplicador) between two requesters: port 0 is the MIPS MULT path, port 1 is the auxiliary/coprocessor path.
- Arbitrates round-robin, latches the winner's operands and pulses the multiplier start.
- Waits for Done, then returns the 32-bit product to the winner through a valid/ready handshake.
- A watchdog aborts a multiplication that never completes.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH
TIMEOUT, 64, max cycles in WAIT before abort; counter width is clog2(TIMEOUT+1)

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
req0  in  1  requester 0 wants a multiplication; held until ack0
a0  in  WIDTH  requester 0 multiplicador operand
b0  in  WIDTH  requester 0 multiplicando operand
ack0  out  1  one-cycle pulse: operands of requester 0 captured
res_valid0  out  1  result for requester 0 available
res_ready0  in  1  requester 0 accepts result
req1, a1, b1, ack1, res_valid1, res_ready1  same as above, for requester 1
res  out  2*WIDTH  product, shared; valid when res_valid0 or res_valid1 is high
err  out  1  result carries a timeout abort (res forced to 0)
busy  out  1  FSM not in IDLE
mul_start  out  1  to multiplier start; one-cycle pulse
mul_multiplicador2  out  WIDTH  latched operand a
mul_multiplicando  out  WIDTH  latched operand b
mul_produto  in  2*WIDTH  multiplier product
mul_Idle  in  1  multiplier ready for start
mul_Done  in  1  one-cycle pulse, mul_produto valid in the same cycle

Behaviour:
- Reset (rst=0, async):
  - State=IDLE; last-grant pointer=1, so requester 0 wins first.
  - All outputs 0: ack*, res_valid*, mul_start, operands, res, err, busy.
  - Reset mid-operation abandons the transaction; no result is delivered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If (req0|req1) & mul_Idle: grant = the requester not granted last; a lone requester always wins.
  - Latch its a/b into mul_multiplicador2/mul_multiplicando, record the owner, pulse ackN for one cycle, go to ISSUE.
  - If mul_Idle=0: stay, no ack.
- ISSUE: mul_start=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Operands are held stable throughout.
  - On mul_Done: res<=mul_produto, err<=0, go to RESP.
  - If the counter reaches TIMEOUT without mul_Done: res<=0, err<=1, go to RESP.
  - mul_Done in the same cycle as timeout: Done wins, err=0.
- RESP:
  - res_valid(owner)=1; res and err held stable.
  - When res_ready(owner)=1 in a cycle with res_valid high: the transfer completes. Next cycle res_valid=0, update last-grant pointer, go to IDLE.
  - res_ready of the non-owner is ignored.
  - New requests wait; no overlap of transactions.
- Latency: req accepted in IDLE -> ack same cycle -> mul_start next cycle.
  - res_valid rises the cycle after mul_Done.
  - Minimum IDLE->IDLE turnaround = multiplier latency + 3 cycles.
- Fairness: both requesters held high -> grants alternate 0,1,0,1.
- mul_Done outside WAIT is ignored.
- Req dropped before ack is legal, and no transaction starts.
- busy=1 in ISSUE/WAIT/RESP.
- Arithmetic: none in this block; product passes through unmodified (unsigned).

Decomposition:
- Shared package multiplicador_pkg:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - WIDTH default
  - TIMEOUT default
- One natural sub-module, rr_arbiter2: 2-way round-robin grant from req vector and last-grant pointer (combinational grant, registered pointer update pulse).
- Watchdog counter and FSM stay in the top.

Test Plan:
- After reset release: req0 with a0=2001, b0=4001, multiplier model of 16 cycles -> ack0 pulse, mul_start one cycle later, res_valid0 with res=8006001, err=0.
- req0 and req1 asserted together (a1=22, b1=47) -> requester 0 served first (8006001), then requester 1 (1034); ack0 precedes ack1; grants alternate over 4 back-to-back pairs.
- res_ready0 held low 10 cycles in RESP -> res_valid0 and res stable all 10 cycles; no new ack, mul_start stays 0; completes the cycle after res_ready0=1.
- Multiplier model never pulses Done -> after TIMEOUT=64 WAIT cycles res_valid owner=1, err=1, res=0; next transaction is accepted normally.
- rst driven low during WAIT -> all outputs 0 immediately (async); after release, the first grant goes to requester 0 and the next multiply produces the correct result.
- mul_Idle=0 with req1 high for 5 cycles -> no ack1, no mul_start; ack1 the cycle mul_Idle rises.
